// File: rtl/pdm_pkg.sv
// Shared constants for the PDM microphone peripheral: sample format,
// sample buffer depth and TinyQV register map offsets.
package pdm_pkg;

  localparam int unsigned PCM_WIDTH  = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  localparam logic [3:0] REG_SAMPLE    = 4'h8;
  localparam logic [3:0] REG_THRESHOLD = 4'hC;
  localparam logic [3:0] REG_STATUS    = 4'h4;

endpackage

// File: rtl/pdm_valid_edge.sv
// Rising-edge detector for a slow pdm_clk-domain valid level, gated by enable.
// A level already high at reset or while disabled is not treated as a new edge.
module pdm_valid_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic in_valid,
  output logic push_req
);

  logic in_valid_q;
  logic blocked;

  // blocked swallows a level that was already high when capture (re)started;
  // it clears once in_valid is seen low, so only a genuine new rise pushes.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      in_valid_q <= 1'b0;
      blocked    <= in_valid;
    end else begin
      in_valid_q <= in_valid;
      blocked    <= blocked & in_valid;
    end
  end

  assign push_req = enable & in_valid & ~in_valid_q & ~blocked;

endmodule

// File: rtl/pdm_pcm_fifo.sv
// First-word-fall-through PCM sample buffer between the CIC3 decimator and the
// TinyQV register interface, with threshold interrupt and sticky overflow.
module pdm_pcm_fifo
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = PCM_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  input  logic [$clog2(DEPTH):0]     threshold,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_req;
  logic             do_push;
  logic             do_pop;

  pdm_valid_edge u_valid_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_valid (in_valid),
    .push_req (push_req)
  );

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && !do_push) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (threshold != '0) && (level >= threshold);
    end
  end

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// Directed self-checking bench for pdm_pcm_fifo (DEPTH 8, WIDTH 16).
module tb_pdm_pcm_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        rd_en;
  logic        clr_ovf;
  logic [3:0]  threshold;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pdm_pcm_fifo #(.DEPTH(8), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .threshold (threshold),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .irq       (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; clr_ovf = 1'b0; threshold = '0;
    tick();
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_overflow", 32'(overflow), 0);

    rst_n = 1'b1; enable = 1'b1; threshold = 4'd4;
    tick();
    push_sample(16'h1111);
    push_sample(16'h2222);
    push_sample(16'h3333);
    check("lvl3", 32'(level), 3);
    in_data = 16'h4444; in_valid = 1'b1;
    tick();
    check("push4_level", 32'(level), 4);
    check("push4_head", 32'(rd_data), 32'h1111);
    check("push4_irq_lag", 32'(irq), 0);
    tick();
    check("push4_irq", 32'(irq), 1);
    repeat (8) tick();
    in_valid = 1'b0;
    tick();
    check("held_one_push", 32'(level), 4);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop1_head", 32'(rd_data), 32'h2222);
    check("pop1_level", 32'(level), 3);
    check("pop1_irq_lag", 32'(irq), 1);
    tick();
    check("pop1_irq", 32'(irq), 0);
    pop_check("drain_2222", 16'h2222);
    pop_check("drain_3333", 16'h3333);
    pop_check("drain_4444", 16'h4444);
    check("drain_empty", 32'(empty), 1);
    threshold = '0;

    for (int i = 1; i <= 8; i++) push_sample(16'(i));
    check("fill_full", 32'(full), 1);
    check("fill_level", 32'(level), 8);
    check("fill_no_ovf", 32'(overflow), 0);
    push_sample(16'h0009);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_level", 32'(level), 8);
    check("ovf_head_kept", 32'(rd_data), 1);
    for (int i = 1; i <= 8; i++) pop_check("ovf_drain", 16'(i));
    check("ovf_drain_empty", 32'(empty), 1);
    check("ovf_drain_rd0", 32'(rd_data), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    for (int i = 0; i < 8; i++) push_sample(16'(16'h10 + i));
    in_data = 16'h00AA; in_valid = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fullpp_level", 32'(level), 8);
    check("fullpp_ovf", 32'(overflow), 0);
    check("fullpp_head", 32'(rd_data), 32'h11);
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) pop_check("fullpp_drain", 16'(16'h10 + i));
    pop_check("fullpp_tail", 16'h00AA);
    check("fullpp_empty", 32'(empty), 1);

    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_empty_level", 32'(level), 0);
    check("pop_empty_rd", 32'(rd_data), 0);

    in_data = 16'h0055; in_valid = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pp_level", 32'(level), 1);
    check("empty_pp_head", 32'(rd_data), 32'h55);
    in_valid = 1'b0;
    tick();
    pop_check("empty_pp_pop", 16'h0055);

    for (int i = 0; i < 8; i++) push_sample(16'(16'h20 + i));
    in_data = 16'h00BB; in_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_prio", 32'(overflow), 1);
    check("ovf_prio_level", 32'(level), 8);
    check("ovf_prio_head", 32'(rd_data), 32'h20);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) pop_check("prio_drain", 16'(16'h20 + i));
    rd_en = 1'b1; clr_ovf = 1'b0;
    tick();
    rd_en = 1'b0;
    check("prio_empty_level", 32'(level), 0);
    check("prio_ovf_kept", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    push_sample(16'h0031);
    push_sample(16'h0032);
    in_data = 16'h0033; in_valid = 1'b1;
    tick();
    check("dis_pre_level", 32'(level), 3);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("dis_level", 32'(level), 0);
    check("dis_rd", 32'(rd_data), 0);
    check("dis_empty", 32'(empty), 1);
    repeat (3) tick();
    check("dis_no_repush", 32'(level), 0);
    in_valid = 1'b0;
    tick();
    in_data = 16'h0044; in_valid = 1'b1;
    tick();
    check("dis_new_push_lvl", 32'(level), 1);
    check("dis_new_push_data", 32'(rd_data), 32'h44);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_rd", 32'(rd_data), 0);
    repeat (3) tick();
    check("mid_rst_no_push", 32'(level), 0);
    in_valid = 1'b0;
    tick();
    in_data = 16'h0066; in_valid = 1'b1;
    tick();
    check("mid_rst_push", 32'(rd_data), 32'h66);
    in_valid = 1'b0;
    threshold = 4'd1;
    tick();
    check("thr1_irq", 32'(irq), 1);
    threshold = 4'd0;
    tick();
    check("thr0_irq", 32'(irq), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
